// File: rtl/pe_array_ctrl_if.sv
// rtl/pe_array_ctrl_if.sv - vector buffer read bus and result stream bundle
//
// Purpose: groups the vector buffer read port and the result handshake
// stream of pe_array_ctrl.
// Signals:
//   mem_rd_en    buffer read strobe (controller -> buffer)
//   mem_addr     buffer read address (controller -> buffer)
//   mem_rd_data  256-bit read data, valid 1 cycle after mem_rd_en (buffer -> controller)
//   res_valid    result word valid (controller -> consumer)
//   res_ready    consumer accept (consumer -> controller)
//   res_data     32-bit result word
//   res_idx      element index 8r+c
//   res_last     high with index 63
// Modports: master = controller side, slave = buffer/consumer side.
interface pe_array_ctrl_if #(
  parameter int AW = 4
);
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [255:0]  mem_rd_data;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic [5:0]    res_idx;
  logic          res_last;

  modport master (
    output mem_rd_en, mem_addr, res_valid, res_data, res_idx, res_last,
    input  mem_rd_data, res_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, res_valid, res_data, res_idx, res_last,
    output mem_rd_data, res_ready
  );
endinterface

// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - job sequencer for the 8x8 systolic PE array
//
// Purpose: on start, clears the array accumulators, fetches K vectors from the
// vector buffer and streams them into the array, waits (bounded) for the
// array finish flag, then drains the 64 result words over a valid/ready stream.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-low reset
//   start        job request, sampled only when idle
//   base_addr    first vector address, captured on accepted start
//   bus          pe_array_ctrl_if.master: buffer read port + result stream
//   arr_clr_n    1-cycle active-low accumulator clear
//   arr_en       array input valid
//   arr_a        array input vector (buffer data gated by arr_en)
//   arr_finish   array finish flag
//   arr_c        packed 64 x 32-bit results, element k at bits [32k+31:32k]
//   busy         high whenever not idle
//   done         1-cycle pulse at job end
//   timeout_err  sticky timeout flag, cleared by the next accepted start
module pe_array_ctrl #(
  parameter int K       = 8,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  pe_array_ctrl_if.master bus,
  output logic            arr_clr_n,
  output logic            arr_en,
  output logic [255:0]    arr_a,
  input  logic            arr_finish,
  input  logic [2047:0]   arr_c,
  output logic            busy,
  output logic            done,
  output logic            timeout_err
);

  localparam int CW = $clog2(K + 1) + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] K_C  = CW'(K);
  localparam logic [WW-1:0] TO_C = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] base_q;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wcnt;
  logic [CW-1:0] cnt_inc;
  logic [5:0]    nidx;

  assign cnt_inc = cnt + 1'b1;
  assign nidx    = bus.res_idx + 6'd1;

  // Read data arrives one cycle after the strobe, so the registered arr_en
  // (a delayed copy of mem_rd_en) lines up with it; only the gate is combinational.
  assign arr_a = arr_en ? bus.mem_rd_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      base_q        <= '0;
      cnt           <= '0;
      wcnt          <= '0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_idx   <= '0;
      bus.res_last  <= 1'b0;
      arr_clr_n     <= 1'b1;
      arr_en        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            timeout_err <= 1'b0;
            arr_clr_n   <= 1'b0;
            busy        <= 1'b1;
            state       <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          arr_clr_n     <= 1'b1;
          bus.mem_rd_en <= 1'b1;
          bus.mem_addr  <= base_q;
          cnt           <= '0;
          state         <= S_FEED;
        end

        // cnt numbers the FEED cycles 0..K: reads issue in 0..K-1,
        // the matching data is fed in 1..K.
        S_FEED: begin
          if (cnt == K_C) begin
            arr_en        <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            wcnt          <= '0;
            state         <= S_WAIT;
          end else begin
            cnt           <= cnt_inc;
            arr_en        <= 1'b1;
            bus.mem_rd_en <= (cnt_inc < K_C);
            bus.mem_addr  <= base_q + AW'(cnt_inc);
          end
        end

        // Finish is tested before the timeout so it wins on the last cycle.
        S_WAIT: begin
          if (arr_finish) begin
            bus.res_valid <= 1'b1;
            bus.res_idx   <= '0;
            bus.res_data  <= arr_c[31:0];
            bus.res_last  <= 1'b0;
            state         <= S_DRAIN;
          end else if (wcnt == TO_C) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        S_DRAIN: begin
          if (bus.res_ready) begin
            if (bus.res_idx == 6'd63) begin
              bus.res_valid <= 1'b0;
              bus.res_last  <= 1'b0;
              done          <= 1'b1;
              state         <= S_DONE;
            end else begin
              bus.res_idx  <= nidx;
              bus.res_data <= arr_c[{nidx, 5'd0} +: 32];
              bus.res_last <= (nidx == 6'd63);
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb/tb_pe_array_ctrl.sv - directed self-checking bench for pe_array_ctrl
module tb_pe_array_ctrl;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [3:0]      base_addr;
  logic            arr_clr_n;
  logic            arr_en;
  logic [255:0]    arr_a;
  logic            arr_finish;
  logic [2047:0]   arr_c;
  logic            busy;
  logic            done;
  logic            timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  pe_array_ctrl_if #(.AW(4)) bus ();

  pe_array_ctrl #(.K(8), .AW(4), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .bus         (bus),
    .arr_clr_n   (arr_clr_n),
    .arr_en      (arr_en),
    .arr_a       (arr_a),
    .arr_finish  (arr_finish),
    .arr_c       (arr_c),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Vector buffer: word n has every lane equal to n, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= {8{28'd0, bus.mem_addr}};
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [3:0] b, input bit hold);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Entered at cycle 1 (after the accepting edge); leaves at cycle 11, first WAIT cycle.
  task automatic feed_check(input logic [3:0] b, input bit early_fin);
    logic [3:0]   a;
    logic [255:0] ea;
    bit           exp_rd, exp_en;
    check("c1_busy", 256'(busy), 256'(1));
    check("c1_clr_n", 256'(arr_clr_n), 256'(0));
    check("c1_rd_en", 256'(bus.mem_rd_en), 256'(0));
    for (int cyc = 2; cyc <= 11; cyc++) begin
      @(negedge clk);
      if (early_fin && cyc == 5) arr_finish = 1'b1;
      if (early_fin && cyc == 6) arr_finish = 1'b0;
      exp_rd = (cyc <= 9);
      exp_en = (cyc >= 3 && cyc <= 10);
      check("feed_rd_en", 256'(bus.mem_rd_en), 256'(exp_rd));
      if (exp_rd) begin
        a = 4'(int'(b) + cyc - 2);
        check("feed_addr", 256'(bus.mem_addr), 256'(a));
      end
      check("feed_arr_en", 256'(arr_en), 256'(exp_en));
      a  = 4'(int'(b) + cyc - 3);
      ea = exp_en ? {8{28'd0, a}} : 256'd0;
      check("feed_arr_a", arr_a, ea);
      check("feed_clr_n", 256'(arr_clr_n), 256'(1));
    end
    check("wait_busy", 256'(busy), 256'(1));
  endtask

  // Entered in the first cycle with res_valid high.
  task automatic drain(input bit toggle);
    int k   = 0;
    int cyc = 0;
    bit rdy;
    while (k < 64 && cyc < 400) begin
      if (bus.res_valid) begin
        check("res_idx", 256'(bus.res_idx), 256'(k));
        check("res_data", 256'(bus.res_data), 256'(32'h1000 + k));
        check("res_last", 256'(bus.res_last), 256'(k == 63));
        rdy = toggle ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
        bus.res_ready = rdy;
        if (rdy) k++;
      end else begin
        bus.res_ready = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    bus.res_ready = 1'b0;
    check("drain_count", 256'(k), 256'(64));
    if (!toggle) check("drain_cycles", 256'(cyc), 256'(64));
    check("end_done", 256'(done), 256'(1));
    check("end_valid", 256'(bus.res_valid), 256'(0));
    check("end_busy_in_done", 256'(busy), 256'(1));
    @(negedge clk);
    check("end_done_low", 256'(done), 256'(0));
    check("end_busy_low", 256'(busy), 256'(0));
  endtask

  task automatic pulse_finish();
    arr_finish = 1'b1;
    @(negedge clk);
    arr_finish = 1'b0;
    check("valid_after_finish", 256'(bus.res_valid), 256'(1));
  endtask

  initial begin
    int rv_seen;
    rst           = 1'b0;
    start         = 1'b0;
    base_addr     = '0;
    arr_finish    = 1'b0;
    bus.res_ready = 1'b0;
    for (int k = 0; k < 64; k++) arr_c[32*k +: 32] = 32'h1000 + k;
    repeat (3) @(negedge clk);
    check("rst_rd_en", 256'(bus.mem_rd_en), 256'(0));
    check("rst_addr", 256'(bus.mem_addr), 256'(0));
    check("rst_arr_en", 256'(arr_en), 256'(0));
    check("rst_arr_a", arr_a, 256'd0);
    check("rst_clr_n", 256'(arr_clr_n), 256'(1));
    check("rst_valid", 256'(bus.res_valid), 256'(0));
    check("rst_data", 256'(bus.res_data), 256'(0));
    check("rst_idx", 256'(bus.res_idx), 256'(0));
    check("rst_last", 256'(bus.res_last), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_terr", 256'(timeout_err), 256'(0));
    rst = 1'b1;

    // Normal job, base 3, finish 20 cycles into WAIT, ready held high.
    start_job(4'd3, 1'b0);
    feed_check(4'd3, 1'b0);
    repeat (20) @(negedge clk);
    check("wait_no_valid", 256'(bus.res_valid), 256'(0));
    pulse_finish();
    drain(1'b0);
    check("job1_terr", 256'(timeout_err), 256'(0));

    // Timeout: finish never arrives.
    start_job(4'd0, 1'b0);
    feed_check(4'd0, 1'b0);
    rv_seen = 0;
    for (int i = 0; i < 63; i++) begin
      @(negedge clk);
      if (bus.res_valid) rv_seen++;
    end
    check("to_last_wait_terr", 256'(timeout_err), 256'(0));
    check("to_last_wait_done", 256'(done), 256'(0));
    @(negedge clk);
    check("to_terr", 256'(timeout_err), 256'(1));
    check("to_done", 256'(done), 256'(1));
    check("to_no_valid", 256'(rv_seen + int'(bus.res_valid)), 256'(0));
    @(negedge clk);
    check("to_done_low", 256'(done), 256'(0));
    check("to_busy_low", 256'(busy), 256'(0));
    check("to_terr_sticky", 256'(timeout_err), 256'(1));

    // Next start clears the flag; then reset mid-FEED at cycle 5.
    start_job(4'd5, 1'b0);
    check("restart_terr", 256'(timeout_err), 256'(0));
    repeat (4) @(negedge clk);
    check("c5_rd_en", 256'(bus.mem_rd_en), 256'(1));
    check("c5_arr_en", 256'(arr_en), 256'(1));
    rst = 1'b0;
    #1;
    check("mid_rst_rd_en", 256'(bus.mem_rd_en), 256'(0));
    check("mid_rst_arr_en", 256'(arr_en), 256'(0));
    check("mid_rst_arr_a", arr_a, 256'd0);
    check("mid_rst_addr", 256'(bus.mem_addr), 256'(0));
    check("mid_rst_busy", 256'(busy), 256'(0));
    check("mid_rst_clr_n", 256'(arr_clr_n), 256'(1));
    @(negedge clk);
    rst = 1'b1;

    // Clean job after reset, address wrap from 14, stalled drain 1,0,0,1.
    start_job(4'd14, 1'b0);
    feed_check(4'd14, 1'b0);
    pulse_finish();
    drain(1'b1);

    // start held through the job, early finish during FEED ignored.
    start_job(4'd7, 1'b1);
    feed_check(4'd7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("early_fin_ignored", 256'(bus.res_valid), 256'(0));
      @(negedge clk);
    end
    pulse_finish();
    drain(1'b0);
    @(negedge clk);
    check("b2b_busy", 256'(busy), 256'(1));
    check("b2b_clr_n", 256'(arr_clr_n), 256'(0));
    start = 1'b0;
    @(negedge clk);
    check("b2b_rd_en", 256'(bus.mem_rd_en), 256'(1));
    check("b2b_addr", 256'(bus.mem_addr), 256'(7));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_array_ctrl.md
# pe_array_ctrl

Job sequencer for the 8x8 systolic PE array. Takes a start command and fetches K input vectors (8 lanes x 32 bit) from a vector buffer. It streams them into the array with `arr_en`, then waits for the array's finish flag with a timeout. It then drains the 64 result words one per handshake to the downstream consumer. The block sits between the vector buffer/host and the array top-level.

## Interface
Parameters:
- `K`, 8: vectors fed per job (1..2^AW).
- `AW`, 4: vector buffer address width.
- `TIMEOUT`, 64: maximum WAIT cycles before abort (>=1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  job request; sampled only in IDLE.
- `base_addr`  in  AW  first vector address; captured on accepted start.
- `mem_rd_en`  out  1  buffer read strobe.
- `mem_addr`  out  AW  buffer read address.
- `mem_rd_data`  in  256  read data, valid exactly 1 cycle after `mem_rd_en`; lane i = bits [32i+31:32i].
- `arr_clr_n`  out  1  active-low accumulator clear to array, 1-cycle pulse.
- `arr_en`  out  1  array enable / input-valid.
- `arr_a`  out  256  packed array input (input_a_0..7), lane i = bits [32i+31:32i].
- `arr_finish`  in  1  array finish flag; results on `arr_c` valid and held while high and after.
- `arr_c`  in  2048  packed results; element (r,c) at index 8r+c, bits [32(8r+c)+31 : 32(8r+c)].
- `res_valid`  out  1  result word valid.
- `res_ready`  in  1  consumer accept.
- `res_data`  out  32  result word.
- `res_idx`  out  6  element index 8r+c.
- `res_last`  out  1  high with index 63.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  1-cycle pulse at job end (normal or timeout).
- `timeout_err`  out  1  sticky; set on timeout, cleared on next accepted start.

## Operation
- States: IDLE, CLEAR, FEED, WAIT, DRAIN, DONE.
- IDLE: `start`=1 → latch `base_addr`, clear `timeout_err`, go CLEAR.
- CLEAR: 1 cycle; `arr_clr_n`=0 → FEED.
- FEED: lasts K+1 cycles, with a read counter and a feed counter.
  - Cycles 0..K-1: `mem_rd_en`=1, `mem_addr` = base+n mod 2^AW (wraps).
  - Cycles 1..K: `arr_en`=1, `arr_a` = `mem_rd_data`.
  - When `arr_en`=0, `arr_a` = 0.
  - → WAIT.
- WAIT: the wait counter starts at 0 and increments each cycle.
  - `arr_finish`=1 → DRAIN with idx=0.
  - Otherwise, when the counter reaches TIMEOUT-1 → set `timeout_err`, go DONE.
  - If `arr_finish` arrives on the timeout cycle, finish wins.
- DRAIN:
  - `res_valid`=1, `res_data` = `arr_c` element `res_idx`, `res_last` = (idx==63).
  - On `res_valid`&`res_ready`: idx+1; after idx 63 is accepted → DONE.
  - While stalled, data, idx and last stay stable.
- DONE: `done`=1 for 1 cycle → IDLE.
- Ignored inputs:
  - `start` outside IDLE.
  - `arr_finish` outside WAIT.
  - `res_ready` while `res_valid`=0.
- Reset asserted in any state: all outputs go to their reset values immediately and the FSM returns to IDLE. No partial job resumes.

## Timing
- Reset values:
  - `mem_rd_en`, `arr_en`, `res_valid`, `res_last`, `busy`, `done`, `timeout_err` = 0.
  - `mem_addr`, `arr_a`, `res_data`, `res_idx` = 0.
  - `arr_clr_n` = 1.
- All outputs are registered except `arr_a`, which is `mem_rd_data` gated by registered `arr_en`.
- `start` accepted at edge 0 gives:
  - `busy` and `arr_clr_n`=0 during cycle 1.
  - `mem_rd_en` during cycles 2..K+1.
  - `arr_en` during cycles 3..K+2.
  - WAIT from cycle K+3.
- `arr_finish` sampled high at edge f → `res_valid` high from cycle f+1.
- With `res_ready` held high, drain takes 64 cycles. `done` follows the last accept by 1 cycle, and `busy` drops in the same cycle as `done` ends.
- On timeout, `timeout_err` rises together with the DONE state, then `done` pulses. No `res_valid` is issued.
- Throughput: a back-to-back `start` is accepted in the cycle after DONE.

## Test plan
- Default params, base_addr=3, buffer word n = {8{n}}, `arr_finish` pulsed 20 cycles into WAIT, `res_ready`=1:
  - `mem_addr` 3..10 on cycles 2..9.
  - `arr_en` cycles 3..10, `arr_a` lanes = 3..10.
  - 64 results in order with idx 0..63, `res_last` only at 63.
  - `done` pulse; `timeout_err`=0.
- base_addr=14, K=8, AW=4 → addresses 14,15,0,1,..,5 (wrap).
- `arr_finish` never asserted, TIMEOUT=64:
  - `timeout_err`=1 after exactly 64 WAIT cycles, `done` pulses, no `res_valid`.
  - The next `start` clears `timeout_err`.
- DRAIN with `res_ready` toggling 1,0,0,1 and `arr_c` element k = 0x1000+k:
  - `res_data`/`res_idx` hold during stalls.
  - Every index is emitted once; sequence 0x1000..0x103F.
- `rst` pulled low mid-FEED (cycle 5):
  - All outputs at reset values in the same cycle, including `arr_en`=0 and `mem_rd_en`=0.
  - A subsequent start runs a clean job.
- `start` held high through a whole job, `arr_finish` pulsed during FEED:
  - Only one job runs per IDLE visit.
  - The early finish is ignored; WAIT still needs a new finish.
  - A second job starts on the cycle after DONE.
